psum_accumulator: RTL

Output-side accumulation stage for the MAC array. It consumes the partial-sum words produced by a MAC column and accumulates a programmed number of them, e.g. across input-channel passes, with signed saturation. It optionally applies ReLU and hands one finished result downstream through a valid/ready handshake. It honours the same `act_mode` packing as the MAC:
- `act_mode=0`: one 24-bit signed psum per word.
- `act_mode=1`: two independent 12-bit signed lanes per word; lane 1 is `[11:0]`, lane 2 is `[23:12]`.

---
 rtl/psum_accumulator.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/psum_accumulator.sv
// Output-side partial-sum accumulator: sums a programmed number of MAC psums
// with signed saturation (one 24-bit lane or two 12-bit lanes), optional ReLU.
module psum_accumulator #(
  parameter int psum_bw  = 24,
  parameter int psum_bw2 = 12,
  parameter int cnt_bw   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               act_mode,
  input  logic               relu_en,
  input  logic [cnt_bw-1:0]  acc_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [psum_bw-1:0] in_psum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [cnt_bw-1:0]   CNT_ONE  = cnt_bw'(1);
  localparam logic [psum_bw-1:0]  FULL_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0]  FULL_MIN = {1'b1, {(psum_bw-1){1'b0}}};
  localparam logic [psum_bw2-1:0] LANE_MAX = {1'b0, {(psum_bw2-1){1'b1}}};
  localparam logic [psum_bw2-1:0] LANE_MIN = {1'b1, {(psum_bw2-1){1'b0}}};

  state_t               state_q;
  logic [psum_bw-1:0]   acc_q;
  logic [cnt_bw-1:0]    cnt_q;
  logic [cnt_bw-1:0]    len_q;
  logic                 mode_q;
  logic                 relu_q;
  logic [psum_bw-1:0]   out_data_q;

  logic                 xfer;
  logic                 deliver;
  logic [cnt_bw-1:0]    len_in;
  logic [cnt_bw-1:0]    cnt_d;
  logic [psum_bw:0]     sum_full;
  logic [psum_bw2:0]    sum_lo;
  logic [psum_bw2:0]    sum_hi;
  logic [psum_bw-1:0]   sat_full;
  logic [psum_bw2-1:0]  sat_lo;
  logic [psum_bw2-1:0]  sat_hi;
  logic [psum_bw-1:0]   acc_d;

  // ReLU per active lane; in split mode each lane is zeroed on its own sign.
  function automatic logic [psum_bw-1:0] apply_relu(
    input logic [psum_bw-1:0] v,
    input logic               mode,
    input logic               en
  );
    logic [psum_bw-1:0] r;
    r = v;
    if (en) begin
      if (mode) begin
        if (v[psum_bw2-1]) r[psum_bw2-1:0] = '0;
        if (v[psum_bw-1])  r[psum_bw-1:psum_bw2] = '0;
      end else if (v[psum_bw-1]) begin
        r = '0;
      end
    end
    return r;
  endfunction

  assign in_ready  = (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;

  assign xfer    = in_valid && in_ready;
  assign deliver = out_valid && out_ready;
  assign len_in  = (acc_len == '0) ? CNT_ONE : acc_len;
  assign cnt_d   = cnt_q + CNT_ONE;

  always_comb begin
    sum_full = {acc_q[psum_bw-1], acc_q} + {in_psum[psum_bw-1], in_psum};
    sum_lo   = {acc_q[psum_bw2-1], acc_q[psum_bw2-1:0]}
             + {in_psum[psum_bw2-1], in_psum[psum_bw2-1:0]};
    sum_hi   = {acc_q[psum_bw-1], acc_q[psum_bw-1:psum_bw2]}
             + {in_psum[psum_bw-1], in_psum[psum_bw-1:psum_bw2]};

    // Overflow shows up as disagreement between the guard bit and the sign bit.
    if (sum_full[psum_bw] != sum_full[psum_bw-1])
      sat_full = sum_full[psum_bw] ? FULL_MIN : FULL_MAX;
    else
      sat_full = sum_full[psum_bw-1:0];

    if (sum_lo[psum_bw2] != sum_lo[psum_bw2-1])
      sat_lo = sum_lo[psum_bw2] ? LANE_MIN : LANE_MAX;
    else
      sat_lo = sum_lo[psum_bw2-1:0];

    if (sum_hi[psum_bw2] != sum_hi[psum_bw2-1])
      sat_hi = sum_hi[psum_bw2] ? LANE_MIN : LANE_MAX;
    else
      sat_hi = sum_hi[psum_bw2-1:0];

    acc_d = mode_q ? {sat_hi, sat_lo} : sat_full;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            mode_q <= act_mode;
            relu_q <= relu_en;
            len_q  <= len_in;
            acc_q  <= in_psum;
            cnt_q  <= CNT_ONE;
            // Single-psum results bypass ACC, so use the live config here.
            if (len_in == CNT_ONE) begin
              out_data_q <= apply_relu(in_psum, act_mode, relu_en);
              state_q    <= OUT;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (xfer) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              out_data_q <= apply_relu(acc_d, mode_q, relu_q);
              state_q    <= OUT;
            end
          end
        end
        OUT: begin
          if (deliver) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
